// File: rtl/sensor_sequencer.sv
// Frame sequencer for the pixel sensor array: erase, expose, Gray-ramp convert
// and row-by-row read, with start handshake, continuous mode and abort.
module sensor_sequencer #(
   parameter int ROWS            = 2,
   parameter int RAMP_BITS       = 8,
   parameter int ROW_READ_CYCLES = 5,
   parameter int CNT_BITS        = 12
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 START,
   input  logic                 CONTINUOUS,
   input  logic                 ABORT,
   input  logic [CNT_BITS-1:0]  ERASE_CYCLES,
   input  logic [CNT_BITS-1:0]  EXPOSE_CYCLES,
   output logic                 PIXEL_ERASE,
   output logic                 PIXEL_EXPOSE,
   output logic                 RAMP_ACTIVE,
   output logic [RAMP_BITS-1:0] PIXEL_DIGITAL_RAMP,
   output logic [ROWS-1:0]      SENSOR_ROW_SELECT,
   output logic                 NEW_ROW,
   output logic                 FRAME_DONE,
   output logic                 BUSY,
   output logic [2:0]           PHASE
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CNT_BITS-1:0] CONV_LAST = CNT_BITS'((2 ** RAMP_BITS) - 1);
   localparam logic [CNT_BITS-1:0] ROW_LAST  = CNT_BITS'(ROW_READ_CYCLES - 1);
   localparam logic [RW-1:0]       LAST_ROW  = RW'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ERASE   = 3'd1,
      S_EXPOSE  = 3'd2,
      S_CONVERT = 3'd3,
      S_READ    = 3'd4
   } state_t;

   state_t              r_state, w_nstate;
   logic [CNT_BITS-1:0] r_cnt, w_ncnt;
   logic [CNT_BITS-1:0] r_erase_last, r_expose_last;
   logic [CNT_BITS-1:0] w_erase_last, w_expose_last;
   logic [RW-1:0]       r_row, w_nrow;
   logic                r_cont, w_done, w_start, w_abort;
   logic [RAMP_BITS-1:0] w_bin, w_gray;

   // Durations are stored as "last count" so a zero request behaves like one cycle.
   assign w_erase_last  = (ERASE_CYCLES  == '0) ? '0 : ERASE_CYCLES  - 1'b1;
   assign w_expose_last = (EXPOSE_CYCLES == '0) ? '0 : EXPOSE_CYCLES - 1'b1;
   assign w_abort       = ABORT && (r_state != S_IDLE);
   assign w_bin         = w_ncnt[RAMP_BITS-1:0];
   assign w_gray        = w_bin ^ (w_bin >> 1);
   assign PHASE         = r_state;

   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt + 1'b1;
      w_nrow   = r_row;
      w_done   = 1'b0;
      w_start  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ncnt = '0;
            w_nrow = '0;
            if (START && !ABORT) begin
               w_nstate = S_ERASE;
               w_start  = 1'b1;
            end
         end
         S_ERASE: if (r_cnt == r_erase_last) begin
            w_nstate = S_EXPOSE;
            w_ncnt   = '0;
         end
         S_EXPOSE: if (r_cnt == r_expose_last) begin
            w_nstate = S_CONVERT;
            w_ncnt   = '0;
         end
         S_CONVERT: if (r_cnt == CONV_LAST) begin
            w_nstate = S_READ;
            w_ncnt   = '0;
            w_nrow   = '0;
         end
         S_READ: if (r_cnt == ROW_LAST) begin
            w_ncnt = '0;
            if (r_row == LAST_ROW) begin
               w_done   = 1'b1;
               w_nrow   = '0;
               w_nstate = r_cont ? S_ERASE : S_IDLE;
            end else begin
               w_nrow = r_row + 1'b1;
            end
         end
         default: w_nstate = S_IDLE;
      endcase
      if (w_abort) begin
         w_nstate = S_IDLE;
         w_ncnt   = '0;
         w_nrow   = '0;
         w_done   = 1'b0;
      end
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state            <= S_IDLE;
         r_cnt              <= '0;
         r_row              <= '0;
         r_cont             <= 1'b0;
         r_erase_last       <= '0;
         r_expose_last      <= '0;
         PIXEL_ERASE        <= 1'b0;
         PIXEL_EXPOSE       <= 1'b0;
         RAMP_ACTIVE        <= 1'b0;
         PIXEL_DIGITAL_RAMP <= '0;
         SENSOR_ROW_SELECT  <= '0;
         NEW_ROW            <= 1'b0;
         FRAME_DONE         <= 1'b0;
         BUSY               <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_row   <= w_nrow;
         if (w_start) begin
            r_erase_last  <= w_erase_last;
            r_expose_last <= w_expose_last;
            r_cont        <= CONTINUOUS;
         end else if (w_abort) begin
            r_cont <= 1'b0;
         end
         PIXEL_ERASE        <= (w_nstate == S_ERASE);
         PIXEL_EXPOSE       <= (w_nstate == S_EXPOSE);
         RAMP_ACTIVE        <= (w_nstate == S_CONVERT);
         PIXEL_DIGITAL_RAMP <= (w_nstate == S_CONVERT) ? w_gray : '0;
         SENSOR_ROW_SELECT  <= (w_nstate == S_READ) ? (ROWS'(1) << w_nrow) : '0;
         NEW_ROW            <= (w_nstate == S_READ) && (w_ncnt == '0);
         FRAME_DONE         <= w_done;
         BUSY               <= (w_nstate != S_IDLE);
      end
   end

endmodule

// File: tb/tb_sensor_sequencer.sv
// Randomized bench for sensor_sequencer: two configurations share the stimulus and
// are compared every cycle against a frame-timeline reference model.
module tb_sensor_sequencer;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        START = 1'b0, CONTINUOUS = 1'b0, ABORT = 1'b0;
   logic [11:0] EC = '0, XC = '0;

   logic       a_er, a_ex, a_ra, a_nr, a_fd, a_bz;
   logic [7:0] a_ramp;
   logic [1:0] a_sel;
   logic [2:0] a_ph;
   logic       b_er, b_ex, b_ra, b_nr, b_fd, b_bz;
   logic [3:0] b_ramp;
   logic [3:0] b_sel;
   logic [2:0] b_ph;

   int n_chk = 0, n_pass = 0;

   always #5 CLK = ~CLK;

   sensor_sequencer u_a (
      .CLK(CLK), .RESET(RESET), .START(START), .CONTINUOUS(CONTINUOUS), .ABORT(ABORT),
      .ERASE_CYCLES(EC), .EXPOSE_CYCLES(XC),
      .PIXEL_ERASE(a_er), .PIXEL_EXPOSE(a_ex), .RAMP_ACTIVE(a_ra),
      .PIXEL_DIGITAL_RAMP(a_ramp), .SENSOR_ROW_SELECT(a_sel), .NEW_ROW(a_nr),
      .FRAME_DONE(a_fd), .BUSY(a_bz), .PHASE(a_ph));

   sensor_sequencer #(.ROWS(4), .RAMP_BITS(4), .ROW_READ_CYCLES(2), .CNT_BITS(12)) u_b (
      .CLK(CLK), .RESET(RESET), .START(START), .CONTINUOUS(CONTINUOUS), .ABORT(ABORT),
      .ERASE_CYCLES(EC), .EXPOSE_CYCLES(XC),
      .PIXEL_ERASE(b_er), .PIXEL_EXPOSE(b_ex), .RAMP_ACTIVE(b_ra),
      .PIXEL_DIGITAL_RAMP(b_ramp), .SENSOR_ROW_SELECT(b_sel), .NEW_ROW(b_nr),
      .FRAME_DONE(b_fd), .BUSY(b_bz), .PHASE(b_ph));

   // Model: a running frame is just an offset k into erase|expose|convert|read.
   bit mact[2], mcont[2], mdone[2];
   int mk[2], mE[2], mX[2];

   function automatic int prows(int m); return (m == 0) ? 2 : 4; endfunction
   function automatic int prb(int m);   return (m == 0) ? 8 : 4; endfunction
   function automatic int prrc(int m);  return (m == 0) ? 5 : 2; endfunction
   function automatic int ftot(int m);
      return mE[m] + mX[m] + (1 << prb(m)) + prows(m) * prrc(m);
   endfunction

   task automatic mreset();
      for (int m = 0; m < 2; m++) begin
         mact[m] = 0; mcont[m] = 0; mdone[m] = 0; mk[m] = 0;
      end
   endtask

   task automatic step(int m);
      mdone[m] = 0;
      if (!mact[m]) begin
         if (START && !ABORT) begin
            mact[m] = 1; mk[m] = 0; mcont[m] = CONTINUOUS;
            mE[m] = (EC == 0) ? 1 : int'(EC);
            mX[m] = (XC == 0) ? 1 : int'(XC);
         end
      end else if (ABORT) begin
         mact[m] = 0; mcont[m] = 0;
      end else begin
         mk[m]++;
         if (mk[m] == ftot(m)) begin
            mdone[m] = 1;
            if (mcont[m]) mk[m] = 0;
            else mact[m] = 0;
         end
      end
   endtask

   function automatic logic [63:0] expv(int m);
      logic [2:0]  ph = 0;
      logic        bz = 0, er = 0, ex = 0, ra = 0, nr = 0;
      logic [7:0]  sel = 0;
      logic [15:0] rp = 0;
      int k, e, x, r, j, b;
      if (mact[m]) begin
         bz = 1; k = mk[m]; e = mE[m]; x = mX[m]; r = 1 << prb(m);
         if (k < e) begin ph = 1; er = 1; end
         else if (k < e + x) begin ph = 2; ex = 1; end
         else if (k < e + x + r) begin
            ph = 3; ra = 1; b = k - e - x; rp = 16'(b ^ (b >> 1));
         end else begin
            ph = 4; j = k - e - x - r;
            sel = 8'(1 << (j / prrc(m)));
            nr = ((j % prrc(m)) == 0);
         end
      end
      return 64'({ph, bz, er, ex, ra, nr, mdone[m], sel, rp});
   endfunction

   function automatic logic [63:0] obs(int m);
      if (m == 0)
         return 64'({a_ph, a_bz, a_er, a_ex, a_ra, a_nr, a_fd, 8'(a_sel), 16'(a_ramp)});
      return 64'({b_ph, b_bz, b_er, b_ex, b_ra, b_nr, b_fd, 8'(b_sel), 16'(b_ramp)});
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
   endtask

   task automatic cyc();
      @(posedge CLK);
      if (!RESET) begin step(0); step(1); end
      #1;
      chk("cfgA", obs(0), expv(0));
      chk("cfgB", obs(1), expv(1));
   endtask

   task automatic run(int n);
      repeat (n) cyc();
   endtask

   // Asynchronous reset between edges; outputs must clear before any clock edge.
   task automatic async_reset();
      #2 RESET = 1'b1;
      #1 mreset();
      chk("rstA", obs(0), 64'd0);
      chk("rstB", obs(1), 64'd0);
      cyc();
      RESET = 1'b0;
   endtask

   initial begin
      mreset();
      #1 RESET = 1'b1;
      #1 chk("rst0A", obs(0), 64'd0);
      chk("rst0B", obs(1), 64'd0);
      run(3);
      RESET = 1'b0;
      run(2);

      // Single frame with the default durations; a START mid-frame is ignored.
      EC = 12'd5; XC = 12'd255; CONTINUOUS = 1'b0; START = 1'b1;
      cyc(); START = 1'b0;
      run(300);
      START = 1'b1; cyc(); START = 1'b0;
      run(340);

      // Continuous mode, three frames, then abort inside the third expose.
      CONTINUOUS = 1'b1; START = 1'b1;
      cyc(); START = 1'b0; CONTINUOUS = 1'b0;
      run(526 * 2 + 100);
      ABORT = 1'b1; cyc(); ABORT = 1'b0;
      run(20);
      START = 1'b1; ABORT = 1'b1; cyc();
      START = 1'b0; ABORT = 1'b0;
      run(5);

      // Zero/one durations; START held during READ.
      EC = 12'd0; XC = 12'd1; START = 1'b1;
      cyc(); START = 1'b0;
      run(258);
      START = 1'b1; run(3); START = 1'b0;
      run(40);

      // Reset mid-CONVERT, then a fresh frame.
      EC = 12'd3; XC = 12'd4; START = 1'b1;
      cyc(); START = 1'b0;
      run(20);
      async_reset();
      START = 1'b1; cyc(); START = 1'b0;
      run(300);

      // Random traffic with short durations.
      repeat (3000) begin
         START      = ($urandom_range(0, 3) == 0);
         CONTINUOUS = $urandom_range(0, 1) == 1;
         ABORT      = ($urandom_range(0, 99) == 0);
         EC         = 12'($urandom_range(0, 6));
         XC         = 12'($urandom_range(0, 6));
         cyc();
         if ($urandom_range(0, 499) == 0) async_reset();
      end
      START = 1'b0; ABORT = 1'b0;
      run(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
